// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: trigger, echo timing, stability count.
// Define ULTRASONIC_AVG_EN to output a 4-sample mean distance.
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TICK_DIV       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned PERIOD_CYCLES  = 3000000,
  parameter int unsigned STABLE_TOL     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        echo_i,
  output logic        trigger_o,
  output logic [16:0] distance_o,
  output logic        valid_o,
  output logic        timeout_o,
  output logic [11:0] stable_cnt_o,
  output logic [3:0]  state_o,
  output logic        echo_sync_o
);

  localparam int unsigned CMAX =
    (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);

  localparam logic [16:0] DMAX = 17'h1FFFF;
  localparam logic [11:0] SMAX = 12'hFFF;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TRIG      = 4'd1,
    WAIT_RISE = 4'd2,
    MEASURE   = 4'd3,
    HOLDOFF   = 4'd4
  } state_t;

  state_t state;

  logic s1, s2, s3;
  logic rise_q, fall_q;

  logic [CW-1:0] phase_cnt;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] presc;
  logic [16:0]   acc;
  logic [16:0]   prev;
  logic          have_prev;
  logic [17:0]   diff;
  logic [16:0]   result;

  logic phase_sat;
  logic trig_done;
  logic tmo_hit;
  logic period_end;

  assign phase_sat  = (phase_cnt == CW'(CMAX));
  assign trig_done  = (phase_cnt == CW'(TRIG_CYCLES - 1));
  assign tmo_hit    = (phase_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign period_end = (period_cnt == PW'(PERIOD_CYCLES - 1));

  assign state_o     = state;
  assign echo_sync_o = s2;

  always_comb begin
    diff = '0;
    if (acc >= prev)
      diff = {1'b0, acc} - {1'b0, prev};
    else
      diff = {1'b0, prev} - {1'b0, acc};
  end

`ifdef ULTRASONIC_AVG_EN
  logic [16:0] h0, h1, h2;
  logic [18:0] sum;

  always_comb begin
    sum = {2'b00, acc} + {2'b00, h0} + {2'b00, h1} + {2'b00, h2};
  end

  assign result = sum[18:2];

  // History tracks only completed, non-timeout measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
    end else if (state == MEASURE && fall_q) begin
      h0 <= acc;
      h1 <= h0;
      h2 <= h1;
    end
  end
`else
  assign result = acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= echo_i;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
      fall_q <= ~s2 & s3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      trigger_o    <= 1'b0;
      distance_o   <= '0;
      valid_o      <= 1'b0;
      timeout_o    <= 1'b0;
      stable_cnt_o <= '0;
      phase_cnt    <= '0;
      period_cnt   <= '0;
      presc        <= '0;
      acc          <= '0;
      prev         <= '0;
      have_prev    <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      if (!period_end)
        period_cnt <= period_cnt + 1'b1;
      if (!phase_sat)
        phase_cnt <= phase_cnt + 1'b1;

      case (state)
        IDLE: begin
          trigger_o <= 1'b0;
          if (enable_i) begin
            state      <= TRIG;
            trigger_o  <= 1'b1;
            phase_cnt  <= '0;
            period_cnt <= '0;
          end
        end

        TRIG: begin
          if (trig_done) begin
            state     <= WAIT_RISE;
            trigger_o <= 1'b0;
            phase_cnt <= '0;
          end
        end

        WAIT_RISE: begin
          if (rise_q) begin
            state     <= MEASURE;
            presc     <= '0;
            acc       <= '0;
            phase_cnt <= '0;
          end else if (tmo_hit) begin
            state        <= HOLDOFF;
            timeout_o    <= 1'b1;
            stable_cnt_o <= '0;
          end
        end

        MEASURE: begin
          if (fall_q) begin
            state      <= HOLDOFF;
            valid_o    <= 1'b1;
            distance_o <= result;
            prev       <= acc;
            have_prev  <= 1'b1;
            if (!have_prev)
              stable_cnt_o <= '0;
            else if (diff <= 18'(STABLE_TOL)) begin
              if (stable_cnt_o != SMAX)
                stable_cnt_o <= stable_cnt_o + 1'b1;
            end else
              stable_cnt_o <= '0;
          end else if (tmo_hit) begin
            state        <= HOLDOFF;
            valid_o      <= 1'b1;
            timeout_o    <= 1'b1;
            distance_o   <= DMAX;
            stable_cnt_o <= '0;
          end else if (s2) begin
            // Count on prescaler zero so a width of N*TICK_DIV reads N.
            if (presc == '0 && acc != DMAX)
              acc <= acc + 1'b1;
            if (presc == TW'(TICK_DIV - 1))
              presc <= '0;
            else
              presc <= presc + 1'b1;
          end
        end

        HOLDOFF: begin
          if (period_end) begin
            if (enable_i) begin
              state      <= TRIG;
              trigger_o  <= 1'b1;
              phase_cnt  <= '0;
              period_cnt <= '0;
            end else
              state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          trigger_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomized bench for ultrasonic_ranger with an event-level model.
// Scaled-down timing parameters keep the run short.
module tb_ultrasonic_ranger;

  localparam int TRIG = 20;
  localparam int TICK = 16;
  localparam int TMO  = 1000;
  localparam int PER  = 2500;
  localparam int TOL  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        echo = 1'b0;
  logic        trigger_o;
  logic [16:0] distance_o;
  logic        valid_o;
  logic        timeout_o;
  logic [11:0] stable_cnt_o;
  logic [3:0]  state_o;
  logic        echo_sync_o;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG),
    .TICK_DIV(TICK),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES(PER),
    .STABLE_TOL(TOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(enable),
    .echo_i(echo),
    .trigger_o(trigger_o),
    .distance_o(distance_o),
    .valid_o(valid_o),
    .timeout_o(timeout_o),
    .stable_cnt_o(stable_cnt_o),
    .state_o(state_o),
    .echo_sync_o(echo_sync_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int kind;
    int w;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  rst_q = 1'b0;
  bit  e1 = 1'b0, e2 = 1'b0;
  int  last_rise = -1;
  int  en_cyc = -1;

  int exp_dist = 0, exp_st = 0, prev = 0;
  bit have_prev = 1'b0;
  int h[3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
    if (rst) begin
      e1 = 1'b0;
      e2 = 1'b0;
    end else begin
      e2 = e1;
      e1 = echo;
    end
  end

  // Per-cycle compare against the event model.
  always @(negedge clk) begin
    ev_t e;
    int  kind_now;
    int  raw;
    int  d;
    kind_now = -1;
    if (cyc > 0) begin
      if (rst_q) begin
        exp_dist = 0;
        exp_st = 0;
        prev = 0;
        have_prev = 1'b0;
        h[0] = 0; h[1] = 0; h[2] = 0;
        q.delete();
      end else if (q.size() != 0 && q[0].c == cyc) begin
        e = q.pop_front();
        kind_now = e.kind;
        if (e.kind == 0) begin
          raw = e.w / TICK;
          if (raw > 131071) raw = 131071;
          if (!have_prev)
            exp_st = 0;
          else begin
            d = (raw > prev) ? raw - prev : prev - raw;
            if (d <= TOL)
              exp_st = (exp_st < 4095) ? exp_st + 1 : 4095;
            else
              exp_st = 0;
          end
          prev = raw;
          have_prev = 1'b1;
`ifdef ULTRASONIC_AVG_EN
          exp_dist = (raw + h[0] + h[1] + h[2]) / 4;
          h[2] = h[1];
          h[1] = h[0];
          h[0] = raw;
`else
          exp_dist = raw;
`endif
        end else if (e.kind == 1) begin
          exp_st = 0;
        end else begin
          exp_st = 0;
          exp_dist = 131071;
        end
      end
      chk("valid", valid_o, (kind_now == 0 || kind_now == 2));
      chk("timeout", timeout_o, (kind_now == 1 || kind_now == 2));
      chk("distance", distance_o, exp_dist);
      chk("stable", stable_cnt_o, exp_st);
      chk("echo_sync", echo_sync_o, e2);
      if (rst_q) begin
        chk("reset_state", state_o, 0);
        chk("reset_trigger", trigger_o, 0);
      end
    end
  end

  task automatic trig_cycle(output int f);
    int n, r, w;
    n = 0;
    while (trigger_o !== 1'b1 && n < PER + 100) begin
      @(negedge clk);
      n++;
    end
    chk("trig_rise_seen", trigger_o, 1);
    r = cyc;
    if (last_rise >= 0) chk("trig_period", r - last_rise, PER);
    if (en_cyc >= 0) begin
      chk("trig_latency", r - en_cyc, 1);
      en_cyc = -1;
    end
    last_rise = r;
    w = 0;
    while (trigger_o === 1'b1 && w < TRIG + 50) begin
      @(negedge clk);
      w++;
    end
    chk("trig_width", w, TRIG);
    f = cyc;
  endtask

  task automatic meas(input int kind, input int w, input int d,
                      input bit drop_en);
    int  f, n;
    ev_t e;
    trig_cycle(f);
    if (kind == 0) begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      if (drop_en) enable = 1'b0;
      repeat (w) @(negedge clk);
      echo = 1'b0;
      e.c = cyc + 4; e.kind = 0; e.w = w;
      q.push_back(e);
    end else if (kind == 1) begin
      e.c = f + TMO; e.kind = 1; e.w = 0;
      q.push_back(e);
    end else begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      e.c = cyc + 4 + TMO; e.kind = 2; e.w = 0;
      q.push_back(e);
      repeat (TMO + 20) @(negedge clk);
      echo = 1'b0;
    end
    n = 0;
    while (q.size() != 0 && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk("event_reached", q.size(), 0);
    q.delete();
    @(negedge clk);
  endtask

  initial begin
    int f, w, pw, seen;
    h[0] = 0; h[1] = 0; h[2] = 0;
    repeat (5) @(negedge clk);
    chk("rst_distance", distance_o, 0);
    chk("rst_stable", stable_cnt_o, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (trigger_o !== 1'b0) seen = 1;
    end
    chk("idle_no_trigger", seen, 0);
    chk("idle_state", state_o, 0);

    en_cyc = cyc;
    enable = 1'b1;
    meas(0, 480, 300, 1'b0);
`ifdef ULTRASONIC_AVG_EN
    chk("lit_d1", distance_o, 7);
`else
    chk("lit_d1", distance_o, 30);
`endif
    chk("lit_s1", stable_cnt_o, 0);
    meas(0, 576, 150, 1'b0);
`ifdef ULTRASONIC_AVG_EN
    chk("lit_d2", distance_o, 16);
`else
    chk("lit_d2", distance_o, 36);
`endif
    chk("lit_s2", stable_cnt_o, 1);
    meas(0, 800, 50, 1'b0);
`ifdef ULTRASONIC_AVG_EN
    chk("lit_d3", distance_o, 29);
`else
    chk("lit_d3", distance_o, 50);
`endif
    chk("lit_s3", stable_cnt_o, 0);

    meas(1, 0, 0, 1'b0);
`ifdef ULTRASONIC_AVG_EN
    chk("noecho_keep", distance_o, 29);
`else
    chk("noecho_keep", distance_o, 50);
`endif
    chk("noecho_stable", stable_cnt_o, 0);

    meas(2, 0, 100, 1'b0);
    chk("stuck_dist", distance_o, 131071);
    chk("stuck_stable", stable_cnt_o, 0);

    pw = 800;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 7) == 0)
        meas(1, 0, 0, 1'b0);
      else begin
        if ($urandom_range(0, 1) == 1) begin
          w = pw + 16 * int'($urandom_range(0, 10)) - 80;
          if (w < 16) w = 16;
          if (w > 800) w = 800;
        end else
          w = 16 * int'($urandom_range(1, 50));
        pw = w;
        meas(0, w, int'($urandom_range(5, 400)), 1'b0);
      end
    end

    meas(0, 320, 40, 1'b1);
    seen = 0;
    repeat (PER + 50) begin
      @(negedge clk);
      if (trigger_o !== 1'b0) seen = 1;
    end
    chk("disable_no_trigger", seen, 0);
    chk("disable_idle", state_o, 0);
    last_rise = -1;
    en_cyc = cyc;
    enable = 1'b1;

    trig_cycle(f);
    repeat (50) @(negedge clk);
    echo = 1'b1;
    repeat (200) @(negedge clk);
    chk("pre_rst_measure", state_o, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", state_o, 0);
    chk("rst_mid_dist", distance_o, 0);
    chk("rst_mid_stable", stable_cnt_o, 0);
    echo = 1'b0;
    rst = 1'b0;
    last_rise = -1;
    en_cyc = cyc;

    meas(0, 160, 20, 1'b0);
`ifdef ULTRASONIC_AVG_EN
    chk("post_rst_dist", distance_o, 2);
`else
    chk("post_rst_dist", distance_o, 10);
`endif
    chk("post_rst_stable", stable_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
